// File: rtl/msg_tx_sequencer_if.sv
// Handshake and configuration bundle between the control logic, the message
// sequencer and the UART TX block.
interface msg_tx_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W:0]    msg_len;
  logic              start;
  logic              repeat_mode;
  logic              abort;
  logic              tx_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  word_idx;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, start, repeat_mode, abort, tx_ready,
    input  tx_valid, tx_data, busy, done, word_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, start, repeat_mode, abort, tx_ready,
    output tx_valid, tx_data, busy, done, word_idx
  );
endinterface

// File: rtl/msg_tx_sequencer.sv
// Streams a programmable-length message from a writable buffer to the UART TX
// over valid/ready, with optional inter-word gap, repeat mode and abort.
//
// state  | meaning
// IDLE   | waiting for start
// SEND   | word presented, waiting for tx_ready
// GAP    | idle cycles between words, tx_valid low
// DONE   | single-shot pass finished, done pulses for one cycle
module msg_tx_sequencer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  msg_tx_sequencer_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int LEN_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]  len_q, len_d, len_clip;
  logic [IDX_W-1:0]  idx_q, idx_d, load_idx, nxt_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              load_en, hs, last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gap_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    load_en  = 1'b0;
    load_idx = idx_q;
    len_clip = (bus.msg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.msg_len;
    hs       = valid_q & bus.tx_ready;
    last     = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    nxt_idx  = last ? '0 : idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.msg_len == '0) begin
            state_d = S_DONE;
          end else begin
            len_d    = len_clip;
            idx_d    = '0;
            load_en  = 1'b1;
            load_idx = '0;
            valid_d  = 1'b1;
            state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (hs) begin
          if (last && !bus.repeat_mode) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            idx_d    = nxt_idx;
            load_en  = 1'b1;
            load_idx = nxt_idx;
          end else begin
            // word_idx already points at the word that follows the gap
            idx_d   = nxt_idx;
            valid_d = 1'b0;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          load_en = 1'b1;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      idx_d   = '0;
      load_en = 1'b0;
    end

    data_d = load_en ? mem_q[load_idx] : data_q;
  end

  assign bus.tx_valid = valid_q;
  assign bus.tx_data  = data_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.word_idx = idx_q;
endmodule

// File: tb/tb_msg_tx_sequencer.sv
// Directed bench for msg_tx_sequencer: a back-to-back build and a GAP_CYCLES=3
// build share the write/config inputs, each has its own start and tx_ready.
module tb_msg_tx_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       repeat_mode, abort;
  logic       start0, start3, ready0, ready3;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] msg [5];
  logic       pat [4];
  int nhs, ndone, h0, h1;

  always #5 clk = ~clk;

  msg_tx_sequencer_if #(.DATA_W(8), .IDX_W(4)) if0 ();
  msg_tx_sequencer_if #(.DATA_W(8), .IDX_W(4)) if3 ();

  assign if0.wr_en = wr_en;         assign if3.wr_en = wr_en;
  assign if0.wr_addr = wr_addr;     assign if3.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;     assign if3.wr_data = wr_data;
  assign if0.msg_len = msg_len;     assign if3.msg_len = msg_len;
  assign if0.repeat_mode = repeat_mode; assign if3.repeat_mode = repeat_mode;
  assign if0.abort = abort;         assign if3.abort = abort;
  assign if0.start = start0;        assign if3.start = start3;
  assign if0.tx_ready = ready0;     assign if3.tx_ready = ready3;

  msg_tx_sequencer #(.DATA_W(8), .DEPTH(16), .IDX_W(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  msg_tx_sequencer #(.DATA_W(8), .DEPTH(16), .IDX_W(4), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    msg = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7A};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    repeat_mode = 1'b0; abort = 1'b0; start0 = 1'b0; start3 = 1'b0;
    ready0 = 1'b0; ready3 = 1'b0;
    repeat (3) tick();
    chk("rst_valid", if0.tx_valid, 0);
    chk("rst_data", if0.tx_data, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_idx", if0.word_idx, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) wr(4'(i), msg[i]);

    // back-to-back, tx_ready tied high
    msg_len = 5'd5; ready0 = 1'b1; start0 = 1'b1;
    tick(); start0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t1_valid", if0.tx_valid, 1);
      chk("t1_data", if0.tx_data, msg[k]);
      chk("t1_idx", if0.word_idx, k);
      chk("t1_done_early", if0.done, 0);
      tick();
    end
    chk("t1_done", if0.done, 1);
    chk("t1_busy_in_done", if0.busy, 1);
    chk("t1_valid_off", if0.tx_valid, 0);
    tick();
    chk("t1_done_clr", if0.done, 0);
    chk("t1_busy_off", if0.busy, 0);

    // tx_ready toggling 1-0-0-1
    start0 = 1'b1;
    tick(); start0 = 1'b0;
    nhs = 0; ndone = 0;
    for (int c = 0; c < 14; c++) begin
      ready0 = pat[c % 4];
      if (if0.tx_valid) begin
        if (nhs < 5) chk("t2_data", if0.tx_data, msg[nhs]);
        else chk("t2_extra_word", if0.tx_valid, 0);
        if (ready0) nhs++;
      end
      if (if0.done) ndone++;
      tick();
    end
    chk("t2_words", nhs, 5);
    chk("t2_done_count", ndone, 1);
    chk("t2_busy", if0.busy, 0);
    ready0 = 1'b1;

    // GAP_CYCLES=3 build, two words
    msg_len = 5'd2; ready3 = 1'b1; start3 = 1'b1;
    tick(); start3 = 1'b0;
    nhs = 0; ndone = 0; h0 = -1; h1 = -1;
    for (int c = 0; c < 12; c++) begin
      if (if3.tx_valid) begin
        if (nhs == 0) begin h0 = c; chk("t3_data0", if3.tx_data, 8'h68); end
        else if (nhs == 1) begin h1 = c; chk("t3_data1", if3.tx_data, 8'h69); end
        else chk("t3_extra_word", if3.tx_valid, 0);
        nhs++;
      end
      if (if3.done) ndone++;
      tick();
    end
    chk("t3_words", nhs, 2);
    chk("t3_first_hs", h0, 0);
    chk("t3_gap_len", h1 - h0 - 1, 3);
    chk("t3_done_count", ndone, 1);

    // repeat mode, cleared during the second pass
    msg_len = 5'd3; repeat_mode = 1'b1; start0 = 1'b1;
    tick(); start0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) repeat_mode = 1'b0;
      chk("t4_valid", if0.tx_valid, 1);
      chk("t4_idx", if0.word_idx, c % 3);
      chk("t4_data", if0.tx_data, msg[c % 3]);
      chk("t4_no_done", if0.done, 0);
      tick();
    end
    chk("t4_done", if0.done, 1);
    tick();
    chk("t4_busy", if0.busy, 0);

    // abort on the 3rd handshake
    msg_len = 5'd5; start0 = 1'b1;
    tick(); start0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_valid", if0.tx_valid, 1);
      chk("t5_data", if0.tx_data, msg[c]);
      if (c == 2) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk("t5_valid_off", if0.tx_valid, 0);
    chk("t5_busy", if0.busy, 0);
    chk("t5_done", if0.done, 0);
    chk("t5_idx", if0.word_idx, 0);
    tick();
    chk("t5_done_later", if0.done, 0);
    chk("t5_valid_later", if0.tx_valid, 0);
    start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("t5_restart_valid", if0.tx_valid, 1);
    chk("t5_restart_data", if0.tx_data, 8'h68);
    chk("t5_restart_idx", if0.word_idx, 0);
    abort = 1'b1;
    tick(); abort = 1'b0;

    // msg_len = 0
    msg_len = 5'd0; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("t6_valid", if0.tx_valid, 0);
    chk("t6_done", if0.done, 1);
    chk("t6_busy", if0.busy, 1);
    tick();
    chk("t6_done_clr", if0.done, 0);
    chk("t6_busy_off", if0.busy, 0);

    // start/msg_len while busy ignored; write to presented address held off
    ready0 = 1'b0; msg_len = 5'd5; start0 = 1'b1;
    tick();
    chk("t7_first", if0.tx_data, 8'h68);
    msg_len = 5'd2; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA;
    tick();
    start0 = 1'b0; wr_en = 1'b0;
    chk("t7_hold_data", if0.tx_data, 8'h68);
    chk("t7_hold_idx", if0.word_idx, 0);
    ready0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t7_data", if0.tx_data, msg[k]);
      tick();
    end
    chk("t7_done", if0.done, 1);
    tick();
    wr(4'd0, 8'h68);

    // msg_len above DEPTH clips to 16
    msg_len = 5'd20; start0 = 1'b1;
    tick(); start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("t8_idx", if0.word_idx, k);
      if (k < 5) chk("t8_data", if0.tx_data, msg[k]);
      tick();
    end
    chk("t8_done", if0.done, 1);
    tick();

    // reset mid-message
    msg_len = 5'd5; start0 = 1'b1;
    tick(); start0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t9_valid", if0.tx_valid, 0);
    chk("t9_data", if0.tx_data, 0);
    chk("t9_busy", if0.busy, 0);
    chk("t9_done", if0.done, 0);
    chk("t9_idx", if0.word_idx, 0);
    rst = 1'b1; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("t9_restart_valid", if0.tx_valid, 1);
    chk("t9_buf0", if0.tx_data, 0);
    tick();
    chk("t9_buf1", if0.tx_data, 0);
    abort = 1'b1;
    tick(); abort = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/msg_tx_sequencer.md
Name: msg_tx_sequencer

Overview:
Parametrised successor to the fixed-string UART byte selector. It holds a writable message buffer of up to DEPTH words and streams a programmable-length message to the UART transmitter over a valid/ready handshake. It supports an optional inter-byte gap, single-shot or repeat mode, and abort. It sits between the top-level control logic and the UART TX block.

Parameters:
DATA_W, 8, width of each message word and of tx_data
DEPTH, 16, message buffer entries (power of 2, >=2)
IDX_W, 4, index width, equal to log2(DEPTH)
GAP_CYCLES, 0, idle cycles inserted after each accepted word (0 = back-to-back)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (logic 0 resets on a clk edge)
wr_en  in  1  buffer write strobe
wr_addr  in  IDX_W  buffer write address
wr_data  in  DATA_W  buffer write data
msg_len  in  IDX_W+1  number of words to send, 0..DEPTH; sampled on accepted start
start  in  1  begin transmission; honoured only in IDLE
repeat_mode  in  1  resend the message continuously; sampled at the end of each pass
abort  in  1  stop the current transmission
tx_ready  in  1  UART TX can accept a word
tx_valid  out  1  tx_data is valid
tx_data  out  DATA_W  current word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at the end of a single-shot pass
word_idx  out  IDX_W  index of the word currently presented

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All buffer entries are cleared to 0.
  - tx_valid, tx_data, busy, done and word_idx all reset to 0.
  - Reset mid-transmission drops the in-flight word.
- Buffer writes:
  - Accepted in any state, visible from the next cycle.
  - Writing the address currently presented does not change tx_data until that word's handshake completes. tx_data is latched on load.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start && msg_len!=0: latch len = min(msg_len, DEPTH), set word_idx=0, load tx_data=buf[0], assert tx_valid. Next state SEND. tx_valid is high 1 cycle after start.
  - start && msg_len==0: go to DONE (done pulses next cycle); no word is sent.
- SEND:
  - tx_valid stays high and tx_data stays stable until tx_valid && tx_ready.
  - On handshake with word_idx < len-1:
    - GAP_CYCLES==0: word_idx+1, load the next word, tx_valid stays high (back-to-back, one word per cycle maximum).
    - Otherwise: drop tx_valid, go to GAP.
  - On handshake with word_idx == len-1:
    - repeat_mode==1: word_idx wraps to 0 and buf[0] is reloaded (via GAP if GAP_CYCLES>0).
    - repeat_mode==0: drop tx_valid, go to DONE.
- GAP:
  - Counts GAP_CYCLES cycles with tx_valid=0.
  - Then loads the next word (or buf[0] on wrap) with tx_valid=1 and returns to SEND.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 in DONE.
- abort (any non-IDLE state):
  - Next state is IDLE; tx_valid=0 next cycle; done is not pulsed; word_idx is cleared.
  - If abort coincides with a handshake, the sink has taken that word, but no further words are sent.
  - abort has priority over start and over wrap.
- Ignored inputs:
  - start while busy is ignored.
  - msg_len changes while busy are ignored.
- Index width: word_idx never exceeds len-1. msg_len > DEPTH is clipped to DEPTH.

Test Plan:
- Load "hitsz" (68 69 74 73 7A) at addresses 0..4, msg_len=5, tx_ready tied 1, GAP_CYCLES=0, start -> tx_valid from cycle+1 for 5 consecutive cycles with data 68,69,74,73,7A; done pulses once, 1 cycle after the last handshake; busy falls with it.
- Same message, tx_ready toggling 1-0-0-1 -> tx_data holds each word unchanged while tx_ready=0; exactly 5 words are accepted in order.
- GAP_CYCLES=3 build, msg_len=2 -> exactly 3 cycles of tx_valid=0 between the two handshakes.
- repeat_mode=1, msg_len=3 -> word sequence 0,1,2,0,1,2,... with no done; clearing repeat_mode during the second pass -> that pass completes, then done pulses.
- abort asserted on the 3rd handshake cycle of a 5-word message -> 3 words accepted, tx_valid=0 next cycle, no done, busy=0; a later start restarts from word 0.
- Edge cases:
  - start with msg_len=0 -> no tx_valid, done pulses 1 cycle later.
  - start while busy -> ignored.
  - rst=0 mid-message -> all outputs 0 next cycle and the buffer reads back 0.
